// File: rtl/ksa8_byte_serial_accumulator.sv
// Byte-serial running-sum accumulator driving one external 8-bit adder, plus the
// ksa8 Kogge-Stone adder it is intended to be paired with.

module ksa8 (
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   output logic [7:0] o_sum,
   output logic       o_cout
);

   logic [7:0] w_g0, w_p0, w_g1, w_p1, w_g2, w_p2, w_g3;

   // Three prefix levels (span 1, 2, 4); w_g3[i] is the carry out of bit i.
   always_comb begin
      w_g0 = i_a & i_b;
      w_p0 = i_a ^ i_b;
      w_g1 = w_g0;
      w_p1 = w_p0;
      for (int i = 1; i < 8; i++) begin
         w_g1[i] = w_g0[i] | (w_p0[i] & w_g0[i-1]);
         w_p1[i] = w_p0[i] & w_p0[i-1];
      end
      w_g2 = w_g1;
      w_p2 = w_p1;
      for (int i = 2; i < 8; i++) begin
         w_g2[i] = w_g1[i] | (w_p1[i] & w_g1[i-2]);
         w_p2[i] = w_p1[i] & w_p1[i-2];
      end
      w_g3 = w_g2;
      for (int i = 4; i < 8; i++) begin
         w_g3[i] = w_g2[i] | (w_p2[i] & w_g2[i-4]);
      end
      o_sum    = w_p0;
      for (int i = 1; i < 8; i++) begin
         o_sum[i] = w_p0[i] ^ w_g3[i-1];
      end
      o_cout = w_g3[7];
   end

endmodule

module ksa8_byte_serial_accumulator #(
   parameter int ACC_BYTES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [7:0]             in_data,
   input  logic                   clear,
   output logic [7:0]             adder_a,
   output logic [7:0]             adder_b,
   input  logic [7:0]             adder_sum,
   input  logic                   adder_cout,
   output logic [8*ACC_BYTES-1:0] acc,
   output logic                   busy,
   output logic                   done,
   output logic                   overflow
);

   localparam int IDX_W = $clog2(ACC_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ACC_BYTES - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ADD  = 1'b1
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [ACC_BYTES-1:0][7:0]  r_acc;
   logic [IDX_W-1:0]           r_idx;
   logic                       r_carry;
   logic [7:0]                 r_sample;
   logic                       r_ovf;
   logic                       r_done;
   logic                       w_last;
   logic                       w_accept;
   logic                       w_clear;

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      busy        = 1'b0;
      adder_a     = 8'h00;
      adder_b     = 8'h00;
      w_accept    = 1'b0;
      w_clear     = 1'b0;
      w_last      = (r_idx == LAST_IDX);
      case (r_state)
         S_IDLE: begin
            // clear wins over a pending sample; rst_n gating keeps ready low during reset
            in_ready = rst_n & ~clear;
            w_clear  = clear;
            w_accept = in_valid & rst_n & ~clear;
            if (w_accept) w_state_nxt = S_ADD;
         end
         S_ADD: begin
            busy    = 1'b1;
            adder_a = r_acc[r_idx];
            adder_b = (r_idx == '0) ? r_sample : {7'b0, r_carry};
            if (w_last) w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_acc    <= '0;
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_sample <= 8'h00;
         r_ovf    <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= 1'b0;
         if (w_clear) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
         end else if (w_accept) begin
            r_sample <= in_data;
            r_idx    <= '0;
         end
         // Every byte is visited regardless of carry so latency stays fixed.
         if (r_state == S_ADD) begin
            r_acc[r_idx] <= adder_sum;
            r_carry      <= adder_cout;
            r_idx        <= r_idx + 1'b1;
            if (w_last) begin
               r_ovf  <= r_ovf | adder_cout;
               r_done <= 1'b1;
               r_idx  <= '0;
            end
         end
      end
   end

   assign acc      = r_acc;
   assign done     = r_done;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_ksa8_byte_serial_accumulator.sv
// Bench for the byte-serial accumulator: 4-byte and 2-byte instances, each paired
// with a ksa8 adder, checked against an arithmetic running-sum model.

module tb_ksa8_byte_serial_accumulator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        clear = 1'b0;
   int          sel = 4;

   int vec = 0;
   int bad = 0;

   always #5 clk = ~clk;

   logic        v4, c4, rdy4, busy4, done4, ovf4, co4;
   logic [7:0]  a4, b4, s4;
   logic [31:0] acc4;
   logic        v2, c2, rdy2, busy2, done2, ovf2, co2;
   logic [7:0]  a2, b2, s2;
   logic [15:0] acc2;

   assign v4 = (sel == 4) & in_valid;
   assign c4 = (sel == 4) & clear;
   assign v2 = (sel == 2) & in_valid;
   assign c2 = (sel == 2) & clear;

   ksa8 u_add4 (.i_a(a4), .i_b(b4), .o_sum(s4), .o_cout(co4));
   ksa8 u_add2 (.i_a(a2), .i_b(b2), .o_sum(s2), .o_cout(co2));

   ksa8_byte_serial_accumulator #(.ACC_BYTES(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_data(in_data),
      .clear(c4), .adder_a(a4), .adder_b(b4), .adder_sum(s4), .adder_cout(co4),
      .acc(acc4), .busy(busy4), .done(done4), .overflow(ovf4)
   );

   ksa8_byte_serial_accumulator #(.ACC_BYTES(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_data(in_data),
      .clear(c2), .adder_a(a2), .adder_b(b2), .adder_sum(s2), .adder_cout(co2),
      .acc(acc2), .busy(busy2), .done(done2), .overflow(ovf2)
   );

   logic [31:0] cur_acc;
   logic        cur_ready, cur_busy, cur_done, cur_ovf;
   assign cur_acc   = (sel == 4) ? acc4  : {16'h0000, acc2};
   assign cur_ready = (sel == 4) ? rdy4  : rdy2;
   assign cur_busy  = (sel == 4) ? busy4 : busy2;
   assign cur_done  = (sel == 4) ? done4 : done2;
   assign cur_ovf   = (sel == 4) ? ovf4  : ovf2;

   // Offers one sample, scribbles on in_valid/in_data while the add runs, and
   // reports cycles-to-done plus how many ADD cycles showed ready high or busy low.
   task automatic send(input logic [7:0] d, output int lat, output int viol, output logic rdy_ok);
      bit got;
      viol = 0;
      @(negedge clk);
      rdy_ok   = cur_ready;
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      @(negedge clk);
      if (cur_ready !== 1'b0 || cur_busy !== 1'b1) viol++;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 40) begin
         @(posedge clk);
         lat++;
         #1;
         if (lat < sel) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (cur_done === 1'b1) got = 1'b1;
         else if (cur_ready !== 1'b0 || cur_busy !== 1'b1) viol++;
      end
      in_valid = 1'b0;
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic test_reset();
      sel = 4;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vec++; if (acc4 !== 32'h0 || acc2 !== 16'h0) begin bad++; $display("FAIL reset_acc: got %h/%h want 0", acc4, acc2); end
      vec++; if ({rdy4, busy4, done4, ovf4} !== 4'b0) begin bad++; $display("FAIL reset_ctrl: ready/busy/done/ovf=%b want 0000", {rdy4, busy4, done4, ovf4}); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      vec++; if (rdy4 !== 1'b1 || rdy2 !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b%b want 11", rdy4, rdy2); end
   endtask

   task automatic test_single();
      int lat, viol;
      logic rdy;
      sel = 4;
      send(8'h05, lat, viol, rdy);
      vec++; if (rdy !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", rdy); end
      vec++; if (lat !== 4) begin bad++; $display("FAIL single_latency: got %0d want 4", lat); end
      vec++; if (viol !== 0) begin bad++; $display("FAIL single_add_ctrl: %0d bad cycles want 0", viol); end
      vec++; if (cur_acc !== 32'h00000005) begin bad++; $display("FAIL single_acc: got %h want 00000005", cur_acc); end
      vec++; if (cur_ovf !== 1'b0) begin bad++; $display("FAIL single_ovf: got %b want 0", cur_ovf); end
      @(negedge clk);
      vec++; if (cur_done !== 1'b0) begin bad++; $display("FAIL single_done_pulse: got %b want 0", cur_done); end
   endtask

   task automatic test_carry();
      int lat, viol;
      logic rdy;
      sel = 4;
      do_clear();
      vec++; if (cur_acc !== 32'h0) begin bad++; $display("FAIL carry_clear: got %h want 0", cur_acc); end
      send(8'hFF, lat, viol, rdy);
      vec++; if (cur_acc !== 32'h000000FF) begin bad++; $display("FAIL carry_preload: got %h want 000000ff", cur_acc); end
      send(8'h01, lat, viol, rdy);
      vec++; if (cur_acc !== 32'h00000100) begin bad++; $display("FAIL carry_ripple: got %h want 00000100", cur_acc); end
      vec++; if (lat !== 4) begin bad++; $display("FAIL carry_latency: got %0d want 4", lat); end
   endtask

   task automatic test_wrap();
      int lat, viol;
      logic rdy;
      sel = 2;
      do_clear();
      for (int i = 0; i < 257; i++) send(8'hFF, lat, viol, rdy);
      vec++; if (cur_acc !== 32'h0000FFFF || cur_ovf !== 1'b0) begin bad++; $display("FAIL wrap_preload: got %h ovf %b want 0000ffff ovf 0", cur_acc, cur_ovf); end
      send(8'h01, lat, viol, rdy);
      vec++; if (cur_acc !== 32'h0 || cur_ovf !== 1'b1) begin bad++; $display("FAIL wrap_overflow: got %h ovf %b want 00000000 ovf 1", cur_acc, cur_ovf); end
      send(8'h02, lat, viol, rdy);
      vec++; if (cur_acc !== 32'h2 || cur_ovf !== 1'b1) begin bad++; $display("FAIL wrap_sticky: got %h ovf %b want 00000002 ovf 1", cur_acc, cur_ovf); end
   endtask

   task automatic test_clear_priority();
      int n;
      sel = 2;
      @(negedge clk);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h33;
      #1;
      vec++; if (cur_ready !== 1'b0) begin bad++; $display("FAIL clrpri_ready: got %b want 0", cur_ready); end
      @(negedge clk);
      clear = 1'b0;
      #1;
      vec++; if (cur_acc !== 32'h0 || cur_ovf !== 1'b0) begin bad++; $display("FAIL clrpri_cleared: got %h ovf %b want 0 ovf 0", cur_acc, cur_ovf); end
      vec++; if (cur_busy !== 1'b0 || cur_ready !== 1'b1) begin bad++; $display("FAIL clrpri_not_taken: busy %b ready %b want 0 1", cur_busy, cur_ready); end
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (cur_done !== 1'b1 && n < 20);
      vec++; if (cur_done !== 1'b1 || cur_acc !== 32'h33) begin bad++; $display("FAIL clrpri_accept: done %b acc %h want 1 00000033", cur_done, cur_acc); end
   endtask

   task automatic test_reset_mid_add();
      int lat, viol;
      logic rdy;
      sel = 4;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h77;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      vec++; if (busy4 !== 1'b1) begin bad++; $display("FAIL midreset_pre_busy: got %b want 1", busy4); end
      rst_n = 1'b0;
      #1;
      vec++; if (acc4 !== 32'h0 || {rdy4, busy4, done4, ovf4} !== 4'b0) begin bad++; $display("FAIL midreset_outputs: acc %h ctrl %b want 0 0000", acc4, {rdy4, busy4, done4, ovf4}); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      vec++; if (rdy4 !== 1'b1) begin bad++; $display("FAIL midreset_ready: got %b want 1", rdy4); end
      send(8'h10, lat, viol, rdy);
      vec++; if (acc4 !== 32'h10 || lat !== 4) begin bad++; $display("FAIL midreset_new_sample: acc %h lat %0d want 00000010 4", acc4, lat); end
   endtask

   task automatic test_random(input int nb);
      longint model, modulus;
      logic   mover;
      logic [31:0] exp;
      logic [7:0]  d;
      int lat, viol;
      logic rdy;
      sel = nb;
      modulus = longint'(1) << (8 * nb);
      do_clear();
      model = 0;
      mover = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         if ($urandom_range(0, 63) == 0) begin
            do_clear();
            model = 0;
            mover = 1'b0;
            vec++; if (cur_acc !== 32'h0 || cur_ovf !== 1'b0) begin bad++; $display("FAIL rand%0d_clear: acc %h ovf %b want 0 0", nb, cur_acc, cur_ovf); end
         end
         d = 8'($urandom);
         send(d, lat, viol, rdy);
         model = model + longint'(d);
         if (model >= modulus) begin
            model = model - modulus;
            mover = 1'b1;
         end
         exp = 32'(model);
         vec++; if (rdy !== 1'b1) begin bad++; $display("FAIL rand%0d_ready[%0d]: got %b want 1", nb, i, rdy); end
         vec++; if (lat !== nb) begin bad++; $display("FAIL rand%0d_latency[%0d]: got %0d want %0d", nb, i, lat, nb); end
         vec++; if (viol !== 0) begin bad++; $display("FAIL rand%0d_add_ctrl[%0d]: %0d bad cycles want 0", nb, i, viol); end
         vec++; if (cur_acc !== exp) begin bad++; $display("FAIL rand%0d_acc[%0d]: got %h want %h", nb, i, cur_acc, exp); end
         vec++; if (cur_ovf !== mover) begin bad++; $display("FAIL rand%0d_ovf[%0d]: got %b want %b", nb, i, cur_ovf, mover); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_carry();
      test_wrap();
      test_clear_priority();
      test_reset_mid_add();
      test_random(4);
      test_random(2);
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
